// File: rtl/sha256_stream_core.sv
// rtl/sha256_stream_core.sv - multi-block SHA-256 compression core with stream handshakes
//
// Purpose: compresses pre-padded 512-bit blocks, chaining the hash state across
// the blocks of a message. UNROLL rounds are executed per clock (1, 2, 4 or 8),
// so each block occupies the core for 64/UNROLL cycles.
//
// Optional feature macro: SHA256_STREAM_CORE_SHA224_EN
//   defined   : mode_224 is latched with every blk_first block; when set, the
//               SHA-224 IV is used and digest[31:0] reads as zero.
//   undefined : mode_224 is ignored, pure SHA-256.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   blk_data      512-bit padded block, word 0 in [511:480]
//   blk_first     block starts a message (chain restarts from IV)
//   blk_last      block ends a message (digest is produced)
//   blk_valid     block present
//   blk_ready     core accepts a block this cycle
//   mode_224      SHA-224 select, sampled with a blk_first block
//   digest        final hash, H0 in [255:224]
//   digest_valid  digest available
//   digest_ready  consumer takes digest

module sha256_stream_core #(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic         mode_224,
    output logic [255:0] digest,
    output logic         digest_valid,
    input  logic         digest_ready
);

    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
        $error("sha256_stream_core: UNROLL must be 1, 2, 4 or 8");
    end

    localparam int NUM_STEPS = 64 / UNROLL;
    // Round-base value seen during the final BUSY cycle of a block.
    localparam logic [5:0] LAST_RND = 6'(64 - UNROLL);

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV256 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV224 [8] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] iv_word(input logic m, input int i);
        return m ? IV224[i] : IV256[i];
    endfunction

    state_t       state_q, state_d;
    logic [31:0]  h_q [8];
    logic [31:0]  h_d [8];
    logic [31:0]  v_q [8];
    logic [31:0]  v_d [8];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [5:0]   rnd_q, rnd_d;
    logic         last_q, last_d;
    logic         mode_q, mode_d;
    logic [255:0] digest_q, digest_d;

    logic         accept;
    logic         finish;
    logic         rel_h;

    // Round datapath: UNROLL chained rounds on the working variables and schedule window.
    logic [31:0]  va [8];
    logic [31:0]  wv [16];
    logic [31:0]  t1, t2, wnew;

`ifndef SHA256_STREAM_CORE_SHA224_EN
    logic unused_mode_224;
    assign unused_mode_224 = mode_224;
`endif

    assign digest = digest_q;

    always_comb begin
        state_d      = state_q;
        blk_ready    = 1'b0;
        digest_valid = 1'b0;
        accept       = 1'b0;
        finish       = 1'b0;
        rel_h        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    accept  = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (rnd_q == LAST_RND) begin
                    finish  = 1'b1;
                    state_d = last_q ? ST_DONE : ST_IDLE;
                end
            end
            ST_DONE: begin
                digest_valid = 1'b1;
                if (digest_ready) begin
                    rel_h   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        va   = v_q;
        wv   = w_q;
        t1   = '0;
        t2   = '0;
        wnew = '0;
        for (int u = 0; u < UNROLL; u++) begin
            t1 = va[7] + bsig1(va[4]) + ((va[4] & va[5]) ^ (~va[4] & va[6]))
                 + K[rnd_q + 6'(u)] + wv[0];
            t2 = bsig0(va[0]) + ((va[0] & va[1]) ^ (va[0] & va[2]) ^ (va[1] & va[2]));
            va[7] = va[6];
            va[6] = va[5];
            va[5] = va[4];
            va[4] = va[3] + t1;
            va[3] = va[2];
            va[2] = va[1];
            va[1] = va[0];
            va[0] = t1 + t2;
            // wv[0] is W[t]; the word appended is W[t+16]. Words beyond W[63] are never consumed.
            wnew = ssig1(wv[14]) + wv[9] + ssig0(wv[1]) + wv[0];
            for (int i = 0; i < 15; i++) begin
                wv[i] = wv[i + 1];
            end
            wv[15] = wnew;
        end
    end

    always_comb begin
        h_d      = h_q;
        v_d      = v_q;
        w_d      = w_q;
        rnd_d    = rnd_q;
        last_d   = last_q;
        mode_d   = mode_q;
        digest_d = digest_q;

        if (accept) begin
            for (int i = 0; i < 16; i++) begin
                w_d[i] = blk_data[511 - 32 * i -: 32];
            end
            last_d = blk_last;
            rnd_d  = '0;
            if (blk_first) begin
`ifdef SHA256_STREAM_CORE_SHA224_EN
                mode_d = mode_224;
`endif
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = iv_word(mode_d, i);
                    v_d[i] = iv_word(mode_d, i);
                end
            end else begin
                v_d = h_q;
            end
        end

        if (state_q == ST_BUSY) begin
            v_d   = va;
            w_d   = wv;
            rnd_d = rnd_q + 6'(UNROLL);
            if (finish) begin
                for (int i = 0; i < 8; i++) begin
                    h_d[i] = h_q[i] + va[i];
                    digest_d[255 - 32 * i -: 32] = h_q[i] + va[i];
                end
                if (mode_q) begin
                    digest_d[31:0] = '0;
                end
                if (!last_q) begin
                    digest_d = digest_q;
                end
            end
        end

        // After a digest is taken, the chain restarts so a blk_first=0 block still hashes correctly.
        if (rel_h) begin
            for (int i = 0; i < 8; i++) begin
                h_d[i] = iv_word(mode_q, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            for (int i = 0; i < 8; i++) begin
                h_q[i] <= IV256[i];
                v_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                w_q[i] <= '0;
            end
            rnd_q    <= '0;
            last_q   <= 1'b0;
            mode_q   <= 1'b0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            w_q      <= w_d;
            rnd_q    <= rnd_d;
            last_q   <= last_d;
            mode_q   <= mode_d;
            digest_q <= digest_d;
        end
    end

endmodule

// File: tb/tb_sha256_stream_core.sv
// tb/tb_sha256_stream_core.sv - directed vector bench for sha256_stream_core

module tb_sha256_stream_core;

    logic         clk;
    logic         rst [2];
    logic [511:0] bd [2];
    logic         bf [2];
    logic         bl [2];
    logic         bv [2];
    logic         br [2];
    logic         md [2];
    logic [255:0] dg [2];
    logic         dv [2];
    logic         dr [2];

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 runs one round per clock, instance 1 four.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        sha256_stream_core #(.UNROLL(g == 0 ? 1 : 4)) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .blk_data     (bd[g]),
            .blk_first    (bf[g]),
            .blk_last     (bl[g]),
            .blk_valid    (bv[g]),
            .blk_ready    (br[g]),
            .mode_224     (md[g]),
            .digest       (dg[g]),
            .digest_valid (dv[g]),
            .digest_ready (dr[g])
        );
    end

    localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] TB0  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                     32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                     32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                     32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TB1  = {448'h0, 32'h00000000, 32'h000001c0};
    localparam logic [255:0] D_ABC = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [255:0] D_TWO = 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
`ifdef SHA256_STREAM_CORE_SHA224_EN
    localparam logic [255:0] D_224 = {224'h23097d22_3405d822_8642a477_bda255b3_2aadbce4_bda0b3f7_e36c9da7, 32'h0};
`else
    localparam logic [255:0] D_224 = D_ABC;
`endif

    typedef struct {
        int           k;
        int           nblk;
        logic [511:0] b0;
        logic [511:0] b1;
        logic         mode;
        logic [255:0] exp;
        int           lat;
    } vec_t;

    vec_t tv [5];

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_block(input int k, input logic [511:0] d, input logic f, input logic l, input logic m);
        int i;
        bd[k] = d; bf[k] = f; bl[k] = l; md[k] = m; bv[k] = 1'b1;
        i = 0;
        while (!br[k] && i < 300) begin
            @(negedge clk);
            i++;
        end
        check("accept", {255'b0, br[k]}, 256'd1);
        @(negedge clk);
        bv[k] = 1'b0;
    endtask

    task automatic wait_ready(input int k, input int exp_lat);
        int lat;
        int bad;
        lat = 1; bad = 0;
        while (!br[k] && lat < 300) begin
            if (dv[k]) bad++;
            @(negedge clk);
            lat++;
        end
        check("no_digest_mid_message", bad, 0);
        check("block_latency", lat, exp_lat);
    endtask

    task automatic wait_digest(input int k, input int exp_lat);
        int lat;
        int bad;
        lat = 1; bad = 0;
        while (!dv[k] && lat < 300) begin
            if (br[k]) bad++;
            @(negedge clk);
            lat++;
        end
        check("ready_low_while_busy", bad, 0);
        check("digest_latency", lat, exp_lat);
    endtask

    task automatic take_digest(input int k);
        dr[k] = 1'b1;
        @(negedge clk);
        dr[k] = 1'b0;
        check("valid_drops", {255'b0, dv[k]}, 256'd0);
        check("ready_after_take", {255'b0, br[k]}, 256'd1);
    endtask

    task automatic run_msg(input vec_t v);
        send_block(v.k, v.b0, 1'b1, v.nblk == 1, v.mode);
        if (v.nblk == 2) begin
            wait_ready(v.k, v.lat);
            send_block(v.k, v.b1, 1'b0, 1'b1, 1'b0);
        end
        wait_digest(v.k, v.lat);
        check("digest", dg[v.k], v.exp);
        take_digest(v.k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        tv[0] = '{k: 0, nblk: 1, b0: ABC, b1: '0,  mode: 1'b0, exp: D_ABC, lat: 65};
        tv[1] = '{k: 0, nblk: 2, b0: TB0, b1: TB1, mode: 1'b0, exp: D_TWO, lat: 65};
        tv[2] = '{k: 1, nblk: 2, b0: TB0, b1: TB1, mode: 1'b0, exp: D_TWO, lat: 17};
        tv[3] = '{k: 1, nblk: 1, b0: ABC, b1: '0,  mode: 1'b0, exp: D_ABC, lat: 17};
        tv[4] = '{k: 0, nblk: 1, b0: ABC, b1: '0,  mode: 1'b1, exp: D_224, lat: 65};

        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; bd[k] = '0; bf[k] = 1'b0; bl[k] = 1'b0;
            bv[k] = 1'b0; md[k] = 1'b0; dr[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b0;
            check("reset_blk_ready", {255'b0, br[k]}, 256'd1);
            check("reset_digest_valid", {255'b0, dv[k]}, 256'd0);
            check("reset_digest", dg[k], 256'd0);
        end

        for (int i = 0; i < 5; i++) begin
            run_msg(tv[i]);
        end

        // Back-pressure: digest held while the next block waits at the input.
        send_block(0, ABC, 1'b1, 1'b1, 1'b0);
        wait_digest(0, 65);
        bd[0] = ABC; bf[0] = 1'b0; bl[0] = 1'b1; bv[0] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("bp_digest_stable", dg[0], D_ABC);
            check("bp_valid_held", {255'b0, dv[0]}, 256'd1);
            check("bp_blk_ready_low", {255'b0, br[0]}, 256'd0);
        end
        dr[0] = 1'b1;
        @(negedge clk);
        dr[0] = 1'b0;
        check("bp_valid_drops", {255'b0, dv[0]}, 256'd0);
        send_block(0, ABC, 1'b0, 1'b1, 1'b0);
        wait_digest(0, 65);
        check("bp_second_digest", dg[0], D_ABC);
        take_digest(0);

        // Reset mid-BUSY abandons the chain; a blk_first=0 block then starts from the IV.
        send_block(0, TB0, 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("busy_blk_ready_low", {255'b0, br[0]}, 256'd0);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        check("rst_blk_ready", {255'b0, br[0]}, 256'd1);
        check("rst_digest_valid", {255'b0, dv[0]}, 256'd0);
        check("rst_digest", dg[0], 256'd0);
        send_block(0, ABC, 1'b0, 1'b1, 1'b0);
        wait_digest(0, 65);
        check("rst_chain_digest", dg[0], D_ABC);
        take_digest(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
